key_input_conditioner: RTL
==========================

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz); legal minimum 2.
REQ-002 SHALL have parameter KEY_ACTIVE_LOW, default 1; when 1 a raw 0 means pressed, when 0 a raw 1 means pressed.
REQ-003 SHALL have parameter COUNTER_WIDTH, default $clog2(DEBOUNCE_CYCLES+1), the per-channel debounce counter width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-005 SHALL have port clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port key_raw, input, 4 bits: raw push-button levels, asynchronous to clock and bouncing.
REQ-008 SHALL have port key, output, 4 bits: registered one-hot pulse, one cycle per accepted press, feeding the lock's key input; 0 when idle.
REQ-009 SHALL have port multi_press, output, 1 bit: registered one-cycle pulse when a press is rejected because two or more keys became pressed together.
REQ-010 SHALL have port key_held, output, 1 bit: registered level, 1 while any debounced key is pressed.

Function
REQ-011 SHALL pass each key_raw bit through a 2-flop synchroniser and normalise it to active-high "pressed".
REQ-012 SHALL give each channel a debounced state and a counter; the counter SHALL clear whenever the synchronised sample equals the debounced state and SHALL increment otherwise.
REQ-013 SHALL toggle the debounced state and clear the counter on the sample that would bring the count to DEBOUNCE_CYCLES, so glitches shorter than DEBOUNCE_CYCLES cycles are discarded.
REQ-014 SHALL saturate the counter below 2^COUNTER_WIDTH-1 and never wrap.
REQ-015 SHALL implement arbitration FSM states IDLE and HELD.
REQ-016 IDLE: if no debounced key is pressed, SHALL stay in IDLE.
REQ-017 IDLE: if exactly one debounced key is pressed, SHALL set key to that one-hot value for one cycle and go to HELD.
REQ-018 IDLE: if two or more debounced keys are pressed, SHALL pulse multi_press, keep key at 0, and go to HELD.
REQ-019 HELD: SHALL stay in HELD with key=0 until every debounced key is released, then return to IDLE; there is no auto-repeat, and extra keys pressed during HELD are ignored.
REQ-020 SHALL assert key exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a stable press (2 synchroniser + DEBOUNCE_CYCLES debounce + 1 output register).
REQ-021 SHALL never assert key and multi_press in the same cycle, and key SHALL never have more than one bit set.
REQ-022 SHALL assign key_held from the OR of the debounced states, registered, so it lags them by one cycle.

Reset
REQ-023 On reset: synchroniser flops and debounced states SHALL be "released", counters 0, FSM IDLE, and key=0, multi_press=0, key_held=0.
REQ-024 After a reset released while a button is held, SHALL re-debounce that button from "released" and produce exactly one key pulse.
REQ-025 A reset asserted mid-debounce or in HELD SHALL abort immediately with no pulse emitted in the reset cycle.

Structure
REQ-026 The shared package digital_lock_pkg SHALL hold the key count (4), the FSM state encodings, and the default DEBOUNCE_CYCLES; the downstream lock imports the same key width from it.
REQ-027 SHALL instantiate sub-module debounce_channel (synchroniser, counter, debounced state) four times; arbitration and output registers stay in the top.

Verification (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
REQ-028 Clean press: key_raw goes 4'b1111 to 4'b1110 and is held 20 cycles -> key=4'b0001 for exactly 1 cycle, 7 edges after first sample; key_held=1 until 1 cycle after debounced release.
REQ-029 Bounce: bit2 toggles every 2 cycles for 10 cycles, then holds 0 -> no pulse during the bounce, then exactly one key=4'b0100.
REQ-030 Simultaneous: bits 0 and 3 go low on the same edge -> multi_press for 1 cycle, key stays 0, FSM returns to IDLE only after both are released.
REQ-031 Hold and add: bit1 is pressed, then bit0 is pressed 10 cycles later while bit1 is still held -> single key=4'b0010 and no further pulse until all keys are released.
REQ-032 Reset mid-hold: reset is pulsed while bit3 is held -> outputs are 0 during reset, then one key=4'b1000 at DEBOUNCE_CYCLES+3 edges after reset deassertion.
REQ-033 Short glitch: bit0 is low for 3 cycles -> no key pulse and key_held stays 0.

Source files
------------

// File: rtl/digital_lock_pkg.sv
// Shared definitions for the digital lock: key count, arbitration state
// encodings and the default debounce length.
package digital_lock_pkg;

    localparam int NUM_KEYS = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchroniser, polarity normalisation and a
// stable-sample counter that flips the debounced "pressed" level.
module debounce_channel
    import digital_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic pressed
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX  = '1;

    logic                     raw_pressed;
    logic                     sync_q1;
    logic                     sync_q2;
    logic [COUNTER_WIDTH-1:0] count;

    // Normalising before the synchroniser lets every flop reset to 0 = released.
    assign raw_pressed = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            count   <= '0;
            pressed <= 1'b0;
        end else begin
            sync_q1 <= raw_pressed;
            sync_q2 <= sync_q1;
            if (sync_q2 == pressed) begin
                count <= '0;
            end else if (count == COUNT_LAST) begin
                // This sample is the DEBOUNCE_CYCLES-th differing one in a row.
                pressed <= ~pressed;
                count   <= '0;
            end else if (count != COUNT_MAX) begin
                count <= count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/key_input_conditioner.sv
// Debounces four push-buttons and turns them into single one-hot key pulses,
// rejecting chords and suppressing repeats until every key is released.
module key_input_conditioner
    import digital_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key,
    output logic                multi_press,
    output logic                key_held,
    output logic                fsm_state
);

    logic [NUM_KEYS-1:0] pressed;
    logic                any_pressed;
    logic                one_pressed;
    arb_state_t          state;
    arb_state_t          state_next;
    logic [NUM_KEYS-1:0] key_next;
    logic                multi_next;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .COUNTER_WIDTH  (COUNTER_WIDTH)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .key_raw(key_raw[i]),
            .pressed(pressed[i])
        );
    end

    assign any_pressed = |pressed;
    assign one_pressed = any_pressed && ((pressed & (pressed - NUM_KEYS'(1))) == '0);

    always_comb begin
        state_next = state;
        key_next   = '0;
        multi_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_pressed) begin
                    state_next = ST_HELD;
                    if (one_pressed) begin
                        key_next = pressed;
                    end else begin
                        multi_next = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                // No repeat and no late additions: wait for a full release.
                if (!any_pressed) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            key         <= '0;
            multi_press <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_next;
            key         <= key_next;
            multi_press <= multi_next;
            key_held    <= any_pressed;
        end
    end

    assign fsm_state = state;

endmodule
